// File: rtl/branch_predictor_if.sv
// Lookup, update and statistics bundle shared by fetch/decode and the predictor.
interface branch_predictor_if #(
    parameter int IDX_W = 4
);
    logic [31:0]      lk_pc4;
    logic             lk_hit;
    logic             lk_taken;
    logic [31:0]      lk_target;
    logic [IDX_W-1:0] lk_ghr;
    logic             upd_valid;
    logic [31:0]      upd_pc4;
    logic             upd_taken;
    logic             upd_pred;
    logic [31:0]      upd_target;
    logic [IDX_W-1:0] upd_ghr;
    logic             inv;
    logic [15:0]      br_cnt;
    logic [15:0]      mis_cnt;

    modport master (
        output lk_pc4, upd_valid, upd_pc4, upd_taken,
        output upd_pred, upd_target, upd_ghr, inv,
        input  lk_hit, lk_taken, lk_target, lk_ghr,
        input  br_cnt, mis_cnt
    );

    modport slave (
        input  lk_pc4, upd_valid, upd_pc4, upd_taken,
        input  upd_pred, upd_target, upd_ghr, inv,
        output lk_hit, lk_taken, lk_target, lk_ghr,
        output br_cnt, mis_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged predictor with saturating counters and branch stats.
// Define BP_GSHARE_EN to XOR a global history register into the index.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int TAG_W   = 8
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [CTR_W-1:0] ctr_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             wr_en;
    logic [CTR_W-1:0] ctr_d;
    logic [31:0]      tgt_d;
    logic [15:0]      br_cnt_q, br_cnt_d;
    logic [15:0]      mis_cnt_q, mis_cnt_d;
    logic             unused_ok;

    assign lk_tag = bp.lk_pc4[TAG_W+IDX_W+1:IDX_W+2];
    assign up_tag = bp.upd_pc4[TAG_W+IDX_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign lk_idx     = bp.lk_pc4[IDX_W+1:2] ^ ghr_q;
    assign up_idx     = bp.upd_pc4[IDX_W+1:2] ^ bp.upd_ghr;
    assign bp.lk_ghr  = ghr_q;
    assign ghr_d      = (ghr_q << 1) | IDX_W'(bp.upd_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (bp.inv) begin
            ghr_q <= '0;
        end else if (bp.upd_valid) begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lk_idx    = bp.lk_pc4[IDX_W+1:2];
    assign up_idx    = bp.upd_pc4[IDX_W+1:2];
    assign bp.lk_ghr = '0;
`endif

    // Untagged PC bits (and upd_ghr without gshare) are intentionally ignored.
    assign unused_ok = ^{bp.lk_pc4, bp.upd_pc4, bp.upd_ghr};

    assign bp.lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.lk_taken  = bp.lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign bp.lk_target = bp.lk_hit ? tgt_q[lk_idx] : 32'h0;
    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        wr_en = 1'b0;
        ctr_d = ctr_q[up_idx];
        tgt_d = tgt_q[up_idx];
        if (bp.upd_valid && !bp.inv) begin
            unique case (1'b1)
                up_hit && bp.upd_taken: begin
                    wr_en = 1'b1;
                    tgt_d = bp.upd_target;
                    if (ctr_q[up_idx] != CTR_MAX) ctr_d = ctr_q[up_idx] + 1'b1;
                end
                up_hit && !bp.upd_taken: begin
                    wr_en = 1'b1;
                    if (ctr_q[up_idx] != '0) ctr_d = ctr_q[up_idx] - 1'b1;
                end
                !up_hit && bp.upd_taken: begin
                    wr_en = 1'b1;
                    ctr_d = CTR_WT;
                    tgt_d = bp.upd_target;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (bp.upd_valid) begin
            if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
            if ((bp.upd_pred != bp.upd_taken) && (mis_cnt_q != 16'hFFFF))
                mis_cnt_d = mis_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else begin
            if (bp.inv) begin
                for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
            end else if (wr_en) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                ctr_q[up_idx]   <= ctr_d;
                tgt_q[up_idx]   <= tgt_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bp.br_cnt  = br_cnt_q;
    assign bp.mis_cnt = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=16, CTR_W=2, TAG_W=8).
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic lk_req = 1'b0;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [15:0] br;
        logic [15:0] mis;
        logic [3:0]  ghr;
    } exp_t;

    exp_t        sbq[$];
    int          m_br = 0;
    int          m_mis = 0;
    logic [3:0]  m_ghr = '0;

    branch_predictor_if #(.IDX_W(4)) bp ();

    branch_predictor #(
        .ENTRIES(16),
        .CTR_W  (2),
        .TAG_W  (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (lk_req) begin
            if (sbq.size() == 0) begin
                chk("sbq_empty", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("hit", 32'(bp.lk_hit), 32'(e.hit));
                chk("taken", 32'(bp.lk_taken), 32'(e.taken));
                chk("target", bp.lk_target, e.tgt);
                chk("ghr", 32'(bp.lk_ghr), 32'(e.ghr));
                chk("br_cnt", 32'(bp.br_cnt), 32'(e.br));
                chk("mis_cnt", 32'(bp.mis_cnt), 32'(e.mis));
            end
        end
    end

    task automatic idle();
        bp.upd_valid  = 1'b0;
        bp.upd_pc4    = '0;
        bp.upd_taken  = 1'b0;
        bp.upd_pred   = 1'b0;
        bp.upd_target = '0;
        bp.upd_ghr    = '0;
        bp.inv        = 1'b0;
        lk_req        = 1'b0;
    endtask

    task automatic upd(logic [31:0] pc, logic tk, logic pr,
                       logic [31:0] tgt, logic [3:0] g, logic iv);
        @(posedge clk);
        #1;
        idle();
        bp.upd_valid  = 1'b1;
        bp.upd_pc4    = pc;
        bp.upd_taken  = tk;
        bp.upd_pred   = pr;
        bp.upd_target = tgt;
        bp.upd_ghr    = g;
        bp.inv        = iv;
        if (m_br < 65535) m_br++;
        if ((pr != tk) && (m_mis < 65535)) m_mis++;
`ifdef BP_GSHARE_EN
        m_ghr = iv ? 4'h0 : {m_ghr[2:0], tk};
`endif
    endtask

    task automatic look(logic [31:0] pc, logic h, logic t, logic [31:0] tgt);
        exp_t e;
        @(posedge clk);
        #1;
        idle();
        bp.lk_pc4 = pc;
        e.hit   = h;
        e.taken = t;
        e.tgt   = tgt;
        e.br    = 16'(m_br);
        e.mis   = 16'(m_mis);
        e.ghr   = m_ghr;
        sbq.push_back(e);
        lk_req = 1'b1;
    endtask

    initial begin
        idle();
        bp.lk_pc4 = '0;
        #12;
        rst_n = 1'b1;
        look(32'h40, 0, 0, 32'h0);
`ifdef BP_GSHARE_EN
        upd(32'h10, 1, 0, 32'h110, 4'h0, 0);
        upd(32'h14, 1, 0, 32'h114, 4'h0, 0);
        look(32'h40, 0, 0, 32'h0);
        upd(32'h40, 1, 0, 32'h140, 4'h3, 0);
        upd(32'hC0, 0, 0, 32'h0, 4'h0, 0);
        upd(32'hC0, 0, 0, 32'h0, 4'h0, 0);
        upd(32'h100, 1, 0, 32'h500, 4'h0, 0);
        upd(32'h104, 1, 0, 32'h504, 4'h0, 0);
        look(32'h40, 1, 1, 32'h140);
        look(32'h100, 0, 0, 32'h0);
`else
        upd(32'h40, 1, 0, 32'h100, 4'h0, 0);
        look(32'h40, 1, 1, 32'h100);
        upd(32'h40, 0, 1, 32'h0, 4'h0, 0);
        upd(32'h40, 0, 0, 32'h0, 4'h0, 0);
        look(32'h40, 1, 0, 32'h100);
        upd(32'h40, 0, 0, 32'h0, 4'h0, 0);
        look(32'h40, 1, 0, 32'h100);
        upd(32'h40, 1, 0, 32'h104, 4'h0, 0);
        look(32'h40, 1, 0, 32'h104);
        for (int i = 0; i < 4; i++) upd(32'h40, 1, 1, 32'h104, 4'h0, 0);
        upd(32'h40, 0, 1, 32'h0, 4'h0, 0);
        look(32'h40, 1, 1, 32'h104);
        upd(32'h40, 0, 1, 32'h0, 4'h0, 0);
        look(32'h40, 1, 0, 32'h104);
        upd(32'h80, 1, 0, 32'h200, 4'h0, 0);
        look(32'h40, 0, 0, 32'h0);
        look(32'h80, 1, 1, 32'h200);
        upd(32'hC0, 0, 0, 32'h0, 4'h0, 0);
        look(32'hC0, 0, 0, 32'h0);
        look(32'h80, 1, 1, 32'h200);
        upd(32'h40, 1, 0, 32'h300, 4'h0, 0);
        upd(32'h44, 1, 1, 32'h344, 4'h0, 0);
        look(32'h40, 1, 1, 32'h300);
        look(32'h44, 1, 1, 32'h344);
        upd(32'h48, 1, 1, 32'h348, 4'h0, 1);
        look(32'h40, 0, 0, 32'h0);
        look(32'h44, 0, 0, 32'h0);
        look(32'h48, 0, 0, 32'h0);
        for (int i = 0; i < 65540; i++) upd(32'hC0, 0, 1, 32'h0, 4'h0, 0);
        look(32'hC0, 0, 0, 32'h0);
        upd(32'h50, 1, 0, 32'h550, 4'h0, 0);
        look(32'h50, 1, 1, 32'h550);
        upd(32'h54, 1, 0, 32'h554, 4'h0, 0);
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        idle();
        m_br  = 0;
        m_mis = 0;
        @(negedge clk);
        rst_n = 1'b1;
        look(32'h50, 0, 0, 32'h0);
        look(32'h54, 0, 0, 32'h0);
`endif
        @(posedge clk);
        #1;
        idle();
        repeat (2) @(posedge clk);
        chk("sbq_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
